pool_layer_1: RTL and testbench

- Binary 2x2, stride-2 max-pooling stage placed directly downstream of the first convolution layer.
- Consumes the 8 one-bit channel streams and their valid strobe in raster order over the 26x26 conv1 feature map.
- Emits a 13x13 pooled map per channel in raster order; one bit per channel per valid output.
- Binary max is logical OR over each 2x2 window.

---
 rtl/pool_layer_1.sv | 123 ++++++++++++
 tb/tb_pool_layer_1.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_layer_1.sv
// ============================================================================
// pool_layer_1 : binary 2x2 stride-2 max-pool (OR) over 8 conv1 channel streams
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pool_layer_1 #(
  parameter int WIDTH  = 26,
  parameter int HEIGHT = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic conv1_out_1,
  input  logic conv1_out_2,
  input  logic conv1_out_3,
  input  logic conv1_out_4,
  input  logic conv1_out_5,
  input  logic conv1_out_6,
  input  logic conv1_out_7,
  input  logic conv1_out_8,
  input  logic valid_in_pool1,
  output logic pool1_out_1,
  output logic pool1_out_2,
  output logic pool1_out_3,
  output logic pool1_out_4,
  output logic pool1_out_5,
  output logic pool1_out_6,
  output logic pool1_out_7,
  output logic pool1_out_8,
  output logic valid_out_pool1,
  output logic frame_done_pool1
);

  localparam int COL_W    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int HALF_W   = WIDTH / 2;
  localparam int IDX_W    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int LAST_ROW = 2 * (HEIGHT / 2) - 1;
  localparam int LAST_IDX = HALF_W - 1;

  logic [7:0]       w_pix;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0]       h_acc_q;
  logic [7:0]       rowbuf_q [HALF_W];
  logic [7:0]       pool_q;
  logic             valid_q;
  logic             done_q;

  logic [IDX_W-1:0] w_idx;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_win;
  logic             w_last_win;
  logic [7:0]       w_pooled;

  assign w_pix = {conv1_out_8, conv1_out_7, conv1_out_6, conv1_out_5,
                  conv1_out_4, conv1_out_3, conv1_out_2, conv1_out_1};

  assign w_idx      = IDX_W'(col_q >> 1);
  assign w_col_last = (col_q == COL_W'(WIDTH - 1));
  assign w_row_last = (row_q == ROW_W'(HEIGHT - 1));
  // Odd row and odd column always close a full window; trailing odd-size edges are even.
  assign w_win      = valid_in_pool1 & col_q[0] & row_q[0];
  assign w_last_win = (row_q == ROW_W'(LAST_ROW)) && (w_idx == IDX_W'(LAST_IDX));
  assign w_pooled   = rowbuf_q[w_idx] | h_acc_q | w_pix;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in_pool1) begin
      if (w_col_last) begin
        col_d = '0;
        row_d = w_row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      h_acc_q <= '0;
      pool_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < HALF_W; i++) begin
        rowbuf_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= w_win;
      done_q  <= w_win & w_last_win;
      if (valid_in_pool1) begin
        if (!col_q[0]) begin
          h_acc_q <= w_pix;
        end else if (!row_q[0]) begin
          rowbuf_q[w_idx] <= h_acc_q | w_pix;
        end
      end
      if (w_win) begin
        pool_q <= w_pooled;
      end
    end
  end

  assign pool1_out_1      = pool_q[0];
  assign pool1_out_2      = pool_q[1];
  assign pool1_out_3      = pool_q[2];
  assign pool1_out_4      = pool_q[3];
  assign pool1_out_5      = pool_q[4];
  assign pool1_out_6      = pool_q[5];
  assign pool1_out_7      = pool_q[6];
  assign pool1_out_8      = pool_q[7];
  assign valid_out_pool1  = valid_q;
  assign frame_done_pool1 = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pool_layer_1.sv
// ============================================================================
// tb_pool_layer_1 : scoreboard bench for pool_layer_1 (26x26 and 5x5 builds)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_pool_layer_1;

  typedef struct {
    logic [7:0] bits;
    logic       fd;
    int         idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix26, pix5;
  logic       val26, val5;
  wire  [7:0] out26, out5;
  wire        vo26, vo5, fd26, fd5;

  exp_t       q26[$];
  exp_t       q5[$];
  logic [7:0] img [0:25][0:25];
  int         n_cmp = 0;
  int         n_err = 0;
  int         ndrv26 = 0, ndrv5 = 0;
  int         nsamp26 = 0, nsamp5 = 0;
  int         cnt26 = 0, cnt5 = 0;
  logic [7:0] last26 = '0, last5 = '0;
  logic       prev26 = 1'b0, prev5 = 1'b0;
  bit         mon_en = 1'b0;

  always #5 clk = ~clk;

  pool_layer_1 #(.WIDTH(26), .HEIGHT(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .conv1_out_1(pix26[0]), .conv1_out_2(pix26[1]), .conv1_out_3(pix26[2]),
    .conv1_out_4(pix26[3]), .conv1_out_5(pix26[4]), .conv1_out_6(pix26[5]),
    .conv1_out_7(pix26[6]), .conv1_out_8(pix26[7]),
    .valid_in_pool1(val26),
    .pool1_out_1(out26[0]), .pool1_out_2(out26[1]), .pool1_out_3(out26[2]),
    .pool1_out_4(out26[3]), .pool1_out_5(out26[4]), .pool1_out_6(out26[5]),
    .pool1_out_7(out26[6]), .pool1_out_8(out26[7]),
    .valid_out_pool1(vo26), .frame_done_pool1(fd26)
  );

  pool_layer_1 #(.WIDTH(5), .HEIGHT(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .conv1_out_1(pix5[0]), .conv1_out_2(pix5[1]), .conv1_out_3(pix5[2]),
    .conv1_out_4(pix5[3]), .conv1_out_5(pix5[4]), .conv1_out_6(pix5[5]),
    .conv1_out_7(pix5[6]), .conv1_out_8(pix5[7]),
    .valid_in_pool1(val5),
    .pool1_out_1(out5[0]), .pool1_out_2(out5[1]), .pool1_out_3(out5[2]),
    .pool1_out_4(out5[3]), .pool1_out_5(out5[4]), .pool1_out_6(out5[5]),
    .pool1_out_7(out5[6]), .pool1_out_8(out5[7]),
    .valid_out_pool1(vo5), .frame_done_pool1(fd5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Count of valid inputs the DUT has actually sampled; pins output latency to one cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      nsamp26 <= 0;
      nsamp5  <= 0;
    end else begin
      if (val26) nsamp26 <= nsamp26 + 1;
      if (val5)  nsamp5  <= nsamp5 + 1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (vo26) begin
        chk("b2b_valid26", {31'b0, prev26}, 32'd0);
        chk("q26_nonempty", {31'b0, q26.size() != 0}, 32'd1);
        if (q26.size() != 0) begin
          e = q26.pop_front();
          chk("data26", {24'b0, out26}, {24'b0, e.bits});
          chk("fdone26", {31'b0, fd26}, {31'b0, e.fd});
          chk("latency26", nsamp26, e.idx);
        end
        last26 = out26;
        cnt26++;
      end else begin
        chk("fd_novalid26", {31'b0, fd26}, 32'd0);
        chk("hold26", {24'b0, out26}, {24'b0, last26});
      end
      prev26 = vo26;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (vo5) begin
        chk("b2b_valid5", {31'b0, prev5}, 32'd0);
        chk("q5_nonempty", {31'b0, q5.size() != 0}, 32'd1);
        if (q5.size() != 0) begin
          e = q5.pop_front();
          chk("data5", {24'b0, out5}, {24'b0, e.bits});
          chk("fdone5", {31'b0, fd5}, {31'b0, e.fd});
          chk("latency5", nsamp5, e.idx);
        end
        last5 = out5;
        cnt5++;
      end else begin
        chk("fd_novalid5", {31'b0, fd5}, 32'd0);
        chk("hold5", {24'b0, out5}, {24'b0, last5});
      end
      prev5 = vo5;
    end
  end

  task automatic set_img(input int mode);
    for (int r = 0; r < 26; r++) begin
      for (int c = 0; c < 26; c++) begin
        case (mode)
          1:       img[r][c] = (r == 3 && c == 5) ? 8'h02 : 8'h00;
          2:       img[r][c] = ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
          3:       img[r][c] = ((r % 2 == 1) && (c % 2 == 1)) ? 8'hFF : 8'h00;
          4:       img[r][c] = 8'($urandom);
          default: img[r][c] = 8'h00;
        endcase
      end
    end
  endtask

  task automatic idle(input int n);
    val26 = 1'b0;
    val5  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame of img; rst_at >= 0 aborts with a one-cycle reset at that pixel.
  task automatic drive_frame(input int sel, input int w, input int h, input int gmax,
                             input int rst_at);
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (r * w + c == rst_at) begin
          rst_n = 1'b0;
          val26 = 1'b0;
          val5  = 1'b0;
          @(posedge clk);
          #1;
          chk("rst_pool26", {24'b0, out26}, 32'd0);
          chk("rst_valid26", {31'b0, vo26}, 32'd0);
          chk("rst_fd26", {31'b0, fd26}, 32'd0);
          rst_n = 1'b1;
          q26.delete();
          q5.delete();
          ndrv26 = 0;
          ndrv5  = 0;
          last26 = '0;
          last5  = '0;
          return;
        end
        repeat ($urandom_range(0, gmax)) begin
          if (sel == 0) begin val26 = 1'b0; pix26 = 8'($urandom); end
          else          begin val5  = 1'b0; pix5  = 8'($urandom); end
          @(posedge clk);
          #1;
        end
        if (sel == 0) begin val26 = 1'b1; pix26 = img[r][c]; ndrv26++; end
        else          begin val5  = 1'b1; pix5  = img[r][c]; ndrv5++;  end
        if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2))) begin
          e.bits = img[r-1][c-1] | img[r-1][c] | img[r][c-1] | img[r][c];
          e.fd   = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
          e.idx  = (sel == 0) ? ndrv26 : ndrv5;
          if (sel == 0) q26.push_back(e);
          else          q5.push_back(e);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run26(input string tag, input int mode, input int gmax);
    set_img(mode);
    cnt26 = 0;
    drive_frame(0, 26, 26, gmax, -1);
    idle(4);
    chk({tag, "_count"}, cnt26, 32'd169);
    chk({tag, "_drained"}, q26.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    val26 = 1'b0;
    val5  = 1'b0;
    pix26 = 8'hFF;
    pix5  = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out26", {24'b0, out26}, 32'd0);
    chk("reset_vo26", {31'b0, vo26}, 32'd0);
    chk("reset_fd26", {31'b0, fd26}, 32'd0);
    chk("reset_out5", {24'b0, out5}, 32'd0);
    chk("reset_vo5", {31'b0, vo5}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run26("zero", 0, 0);
    run26("single", 1, 0);
    run26("checker", 2, 0);
    run26("window_br", 3, 0);
    run26("single_gaps", 1, 5);

    // Mid-frame reset, then a clean frame that must show no stale row-buffer data.
    set_img(2);
    drive_frame(0, 26, 26, 0, 300);
    idle(3);
    run26("post_reset", 4, 0);

    set_img(4);
    cnt26 = 0;
    drive_frame(0, 26, 26, 0, -1);
    set_img(4);
    drive_frame(0, 26, 26, 0, -1);
    idle(4);
    chk("b2b_count", cnt26, 32'd338);
    chk("b2b_drained", q26.size(), 32'd0);

    set_img(4);
    cnt5 = 0;
    drive_frame(1, 5, 5, 0, -1);
    set_img(4);
    drive_frame(1, 5, 5, 2, -1);
    idle(4);
    chk("w5_count", cnt5, 32'd8);
    chk("w5_drained", q5.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
